vga_timing_ctrl: RTL and testbench



---
 rtl/vga_timing_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_vga_timing_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_ctrl
// Purpose  : VGA frame sequencer with a pixel-rate enable, H/V phase FSMs and
//            registered sync, display-enable, position and strobe outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl #(
    parameter int PIX_DIV = 2,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 29,
    parameter int V_DISP  = 480,
    parameter int V_FRONT = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       pix_ce,
    output logic       VGA_HSYNC,
    output logic       VGA_VSYNC,
    output logic       disp_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       line_start,
    output logic       frame_start,
    output logic       busy
);

    localparam int               DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    typedef enum logic {
        TOP_IDLE = 1'b0,
        TOP_RUN  = 1'b1
    } top_state_t;

    typedef enum logic [1:0] {
        PH_SYNC  = 2'd0,
        PH_BACK  = 2'd1,
        PH_DISP  = 2'd2,
        PH_FRONT = 2'd3
    } phase_t;

    top_state_t       top_state, top_next;
    phase_t           h_state, h_next, v_state, v_next;
    logic [9:0]       h_cnt, h_cnt_next, v_cnt, v_cnt_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [9:0]       h_last, v_last;
    logic             h_done, v_done, line_end, frame_end, start;

    logic             pix_ce_next, hsync_next, vsync_next, disp_next;
    logic             line_start_next, frame_start_next, busy_next;
    logic [9:0]       hpos_next, vpos_next;

    function automatic logic [9:0] phase_last(input phase_t ph, input int len_sync,
                                              input int len_back, input int len_disp,
                                              input int len_front);
        int len;
        case (ph)
            PH_SYNC: len = len_sync;
            PH_BACK: len = len_back;
            PH_DISP: len = len_disp;
            default: len = len_front;
        endcase
        return 10'(len - 1);
    endfunction

    always_comb begin
        top_next   = top_state;
        h_next     = h_state;
        v_next     = v_state;
        h_cnt_next = h_cnt;
        v_cnt_next = v_cnt;
        div_next   = div_cnt;
        start      = 1'b0;

        h_last    = phase_last(h_state, H_SYNC, H_BACK, H_DISP, H_FRONT);
        v_last    = phase_last(v_state, V_SYNC, V_BACK, V_DISP, V_FRONT);
        h_done    = pix_ce && (h_cnt == h_last);
        line_end  = h_done && (h_state == PH_FRONT);
        v_done    = line_end && (v_cnt == v_last);
        frame_end = v_done && (v_state == PH_FRONT);

        if (top_state == TOP_IDLE) begin
            start = run;
        end else begin
            div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
            if (pix_ce) begin
                h_cnt_next = h_cnt + 10'd1;
            end
            if (h_done) begin
                h_next     = phase_t'(h_state + 2'd1);
                h_cnt_next = '0;
            end
            if (line_end) begin
                v_cnt_next = v_cnt + 10'd1;
            end
            if (v_done) begin
                v_next     = phase_t'(v_state + 2'd1);
                v_cnt_next = '0;
            end
            // run is only honoured on the frame boundary
            if (frame_end) begin
                start = run;
                if (!run) begin
                    top_next = TOP_IDLE;
                end
            end
        end

        if (start) begin
            top_next = TOP_RUN;
        end
        if (start || (top_next == TOP_IDLE)) begin
            h_next     = PH_SYNC;
            v_next     = PH_SYNC;
            h_cnt_next = '0;
            v_cnt_next = '0;
            div_next   = '0;
        end

        busy_next        = (top_next == TOP_RUN);
        pix_ce_next      = busy_next && (div_next == DIV_LAST);
        hsync_next       = !(busy_next && (h_next == PH_SYNC));
        vsync_next       = !(busy_next && (v_next == PH_SYNC));
        disp_next        = (h_next == PH_DISP) && (v_next == PH_DISP);
        hpos_next        = (h_next == PH_DISP) ? h_cnt_next : '0;
        vpos_next        = (v_next == PH_DISP) ? v_cnt_next : '0;
        line_start_next  = start || (line_end && busy_next);
        frame_start_next = start;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top_state <= TOP_IDLE;
            h_state   <= PH_SYNC;
            v_state   <= PH_SYNC;
            h_cnt     <= '0;
            v_cnt     <= '0;
            div_cnt   <= '0;
        end else begin
            top_state <= top_next;
            h_state   <= h_next;
            v_state   <= v_next;
            h_cnt     <= h_cnt_next;
            v_cnt     <= v_cnt_next;
            div_cnt   <= div_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_ce      <= 1'b0;
            VGA_HSYNC   <= 1'b1;
            VGA_VSYNC   <= 1'b1;
            disp_en     <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            pix_ce      <= pix_ce_next;
            VGA_HSYNC   <= hsync_next;
            VGA_VSYNC   <= vsync_next;
            disp_en     <= disp_next;
            hpos        <= hpos_next;
            vpos        <= vpos_next;
            line_start  <= line_start_next;
            frame_start <= frame_start_next;
            busy        <= busy_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_timing_ctrl
// Purpose  : Directed self-checking bench for vga_timing_ctrl at default
//            timing and at a reduced timing set with PIX_DIV=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, run_a;
    logic       a_pix_ce, a_hsync, a_vsync, a_disp_en, a_line_start, a_frame_start, a_busy;
    logic [9:0] a_hpos, a_vpos;

    logic       rst_b, run_b;
    logic       b_pix_ce, b_hsync, b_vsync, b_disp_en, b_line_start, b_frame_start, b_busy;
    logic [9:0] b_hpos, b_vpos;

    int checks = 0;
    int errors = 0;
    int cyc_a  = 0;
    int cyc_b  = 0;
    int vs_low_a = 0;
    int fs_extra_a = 0;

    vga_timing_ctrl u_dut_dflt (
        .clk         (clk),
        .reset       (rst_a),
        .run         (run_a),
        .pix_ce      (a_pix_ce),
        .VGA_HSYNC   (a_hsync),
        .VGA_VSYNC   (a_vsync),
        .disp_en     (a_disp_en),
        .hpos        (a_hpos),
        .vpos        (a_vpos),
        .line_start  (a_line_start),
        .frame_start (a_frame_start),
        .busy        (a_busy)
    );

    vga_timing_ctrl #(
        .PIX_DIV (1),
        .H_SYNC  (2),
        .H_BACK  (1),
        .H_DISP  (4),
        .H_FRONT (1),
        .V_SYNC  (1),
        .V_BACK  (1),
        .V_DISP  (2),
        .V_FRONT (1)
    ) u_dut_small (
        .clk         (clk),
        .reset       (rst_b),
        .run         (run_b),
        .pix_ce      (b_pix_ce),
        .VGA_HSYNC   (b_hsync),
        .VGA_VSYNC   (b_vsync),
        .disp_en     (b_disp_en),
        .hpos        (b_hpos),
        .vpos        (b_vpos),
        .line_start  (b_line_start),
        .frame_start (b_frame_start),
        .busy        (b_busy)
    );

    wire [6:0] ctl_a = {a_pix_ce, a_hsync, a_vsync, a_disp_en, a_line_start, a_frame_start, a_busy};
    wire [6:0] ctl_b = {b_pix_ce, b_hsync, b_vsync, b_disp_en, b_line_start, b_frame_start, b_busy};

    task automatic step_a();
        @(negedge clk);
        cyc_a++;
    endtask

    task automatic step_b();
        @(negedge clk);
        cyc_b++;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (ctl_a !== 7'b0110000) begin
            errors++;
            $display("FAIL reset_ctl_dflt: got %b expected %b", ctl_a, 7'b0110000);
        end
        checks++;
        if ({a_hpos, a_vpos} !== 20'd0) begin
            errors++;
            $display("FAIL reset_pos_dflt: got hpos=%0d vpos=%0d expected 0/0", a_hpos, a_vpos);
        end
        checks++;
        if (ctl_b !== 7'b0110000) begin
            errors++;
            $display("FAIL reset_ctl_small: got %b expected %b", ctl_b, 7'b0110000);
        end
    endtask

    task automatic test_hsync_line();
        int hs_low   = 0;
        int hs_rise  = -1;
        int ce_cnt   = 0;
        int ls_extra = 0;
        @(negedge clk);
        rst_a = 1'b1;
        run_a = 1'b1;
        @(negedge clk);
        cyc_a = 0;
        // frame_start, line_start, busy, hsync, vsync, pix_ce
        checks++;
        if ({a_frame_start, a_line_start, a_busy, a_hsync, a_vsync, a_pix_ce} !== 6'b111000) begin
            errors++;
            $display("FAIL frame_begin: got %b expected %b",
                     {a_frame_start, a_line_start, a_busy, a_hsync, a_vsync, a_pix_ce}, 6'b111000);
        end
        while (cyc_a < 1600) begin
            if (!a_hsync) hs_low++;
            else if (hs_rise < 0) hs_rise = cyc_a;
            if (!a_vsync) vs_low_a++;
            if (a_pix_ce) ce_cnt++;
            if (cyc_a != 0 && a_line_start) ls_extra++;
            if (cyc_a != 0 && a_frame_start) fs_extra_a++;
            step_a();
        end
        checks++;
        if (hs_low != 192) begin
            errors++;
            $display("FAIL hsync_width: got %0d clks expected 192", hs_low);
        end
        checks++;
        if (hs_rise != 192) begin
            errors++;
            $display("FAIL hsync_rise: got cycle %0d expected 192", hs_rise);
        end
        checks++;
        if (ce_cnt != 800) begin
            errors++;
            $display("FAIL pix_ce_per_line: got %0d expected 800", ce_cnt);
        end
        checks++;
        if (ls_extra != 0) begin
            errors++;
            $display("FAIL line_start_spurious: got %0d expected 0", ls_extra);
        end
        checks++;
        if ({a_line_start, a_hsync, a_frame_start} !== 3'b100) begin
            errors++;
            $display("FAIL line_period: got ls/hs/fs=%b expected 100 at cycle 1600",
                     {a_line_start, a_hsync, a_frame_start});
        end
    endtask

    task automatic test_display_window();
        int         ls_cnt   = 0;
        int         vs_rise  = -1;
        int         de_cnt   = 0;
        int         de_ce    = 0;
        int         hpos_bad = 0;
        int         vpos_bad = 0;
        int         first;
        logic [9:0] exp_h;
        while (!a_disp_en && cyc_a < 52000) begin
            if (!a_vsync) vs_low_a++;
            else if (vs_rise < 0) vs_rise = cyc_a;
            if (a_line_start) ls_cnt++;
            if (a_frame_start) fs_extra_a++;
            step_a();
        end
        checks++;
        if (cyc_a != 49888) begin
            errors++;
            $display("FAIL first_disp_en: got cycle %0d expected 49888", cyc_a);
        end
        checks++;
        if (ls_cnt != 31) begin
            errors++;
            $display("FAIL line_start_count: got %0d expected 31", ls_cnt);
        end
        checks++;
        if (vs_low_a != 3200 || vs_rise != 3200) begin
            errors++;
            $display("FAIL vsync_width: got low=%0d rise=%0d expected 3200/3200", vs_low_a, vs_rise);
        end
        checks++;
        if (fs_extra_a != 0) begin
            errors++;
            $display("FAIL frame_start_spurious: got %0d expected 0", fs_extra_a);
        end
        first = cyc_a;
        while (a_disp_en && cyc_a < first + 2000) begin
            exp_h = 10'((cyc_a - first) / 2);
            if (a_hpos !== exp_h) hpos_bad++;
            if (a_vpos !== 10'd0) vpos_bad++;
            de_cnt++;
            if (a_pix_ce) de_ce++;
            step_a();
        end
        checks++;
        if (de_cnt != 1280 || de_ce != 640) begin
            errors++;
            $display("FAIL disp_en_width: got %0d clks/%0d px expected 1280/640", de_cnt, de_ce);
        end
        checks++;
        if (hpos_bad != 0 || vpos_bad != 0) begin
            errors++;
            $display("FAIL hpos_sequence: got %0d hpos and %0d vpos errors expected 0", hpos_bad, vpos_bad);
        end
        checks++;
        if (a_hpos !== 10'd0) begin
            errors++;
            $display("FAIL hpos_blank: got %0d expected 0", a_hpos);
        end
    endtask

    task automatic test_async_reset();
        int act = 0;
        while (cyc_a < 52088) step_a();
        checks++;
        if ({a_disp_en, a_hpos, a_vpos} !== {1'b1, 10'd300, 10'd1}) begin
            errors++;
            $display("FAIL pre_reset_pos: got de=%b hpos=%0d vpos=%0d expected 1/300/1", a_disp_en, a_hpos, a_vpos);
        end
        #1 rst_a = 1'b0;
        #1;
        checks++;
        if (ctl_a !== 7'b0110000 || {a_hpos, a_vpos} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset: got ctl=%b hpos=%0d vpos=%0d expected 0110000/0/0", ctl_a, a_hpos, a_vpos);
        end
        run_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ctl_a !== 7'b0110000) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL idle_after_reset: got %0d active cycles expected 0", act);
        end
    endtask

    task automatic test_small_frame();
        @(negedge clk);
        rst_b = 1'b1;
        run_b = 1'b1;
        @(negedge clk);
        cyc_b = 0;
        for (int c = 0; c < 80; c++) begin
            int         fc, ln, px;
            logic       hd, vd;
            logic [6:0] exp_ctl;
            logic [9:0] eh, ev;
            fc = c % 40;
            ln = fc / 8;
            px = fc % 8;
            hd = (px >= 3) && (px <= 6);
            vd = (ln == 2) || (ln == 3);
            exp_ctl = {1'b1, px >= 2, ln != 0, hd && vd, px == 0, fc == 0, 1'b1};
            checks++;
            if (ctl_b !== exp_ctl) begin
                errors++;
                $display("FAIL small_ctl c=%0d: got %b expected %b", c, ctl_b, exp_ctl);
            end
            if (hd && vd) begin
                eh = 10'(px - 3);
                ev = 10'(ln - 2);
                checks++;
                if ({b_hpos, b_vpos} !== {eh, ev}) begin
                    errors++;
                    $display("FAIL small_pos c=%0d: got %0d/%0d expected %0d/%0d", c, b_hpos, b_vpos, eh, ev);
                end
            end else if (!hd && !vd) begin
                checks++;
                if ({b_hpos, b_vpos} !== 20'd0) begin
                    errors++;
                    $display("FAIL small_blank_pos c=%0d: got %0d/%0d expected 0/0", c, b_hpos, b_vpos);
                end
            end
            step_b();
        end
    endtask

    task automatic test_run_drop();
        int ls_cnt = 0;
        int drop   = 0;
        int act    = 0;
        while (cyc_b < 96) step_b();
        run_b = 1'b0;
        while (cyc_b < 120) begin
            if (cyc_b == 100) run_b = 1'b1;
            if (cyc_b == 108) run_b = 1'b0;
            if (b_line_start) ls_cnt++;
            if (!b_busy) drop++;
            step_b();
        end
        checks++;
        if (ls_cnt != 3 || drop != 0) begin
            errors++;
            $display("FAIL frame_completes: got %0d lines busy_low=%0d expected 3/0", ls_cnt, drop);
        end
        checks++;
        if (ctl_b !== 7'b0110000) begin
            errors++;
            $display("FAIL return_idle: got %b expected %b", ctl_b, 7'b0110000);
        end
        repeat (10) begin
            step_b();
            if (ctl_b !== 7'b0110000) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL idle_quiet: got %0d active cycles expected 0", act);
        end
        run_b = 1'b1;
        step_b();
        checks++;
        if ({b_frame_start, b_line_start, b_busy, b_hsync, b_vsync, b_pix_ce} !== 6'b111001) begin
            errors++;
            $display("FAIL restart: got %b expected %b",
                     {b_frame_start, b_line_start, b_busy, b_hsync, b_vsync, b_pix_ce}, 6'b111001);
        end
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_a = 1'b0;
        run_a = 1'b0;
        rst_b = 1'b0;
        run_b = 1'b0;
        test_reset();
        test_small_frame();
        test_run_drop();
        test_hsync_line();
        test_display_window();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
